debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised N-channel button debouncer with a 2-flop input synchroniser, a per-channel 4-state debounce FSM and an integrated per-channel timer. It outputs clean levels plus one-cycle press/release pulses. It sits between raw board buttons/switches and user logic such as SSEG counters and menu FSMs, and replaces the single-channel FSM + external timer pair.

## Interface
- N_CH, 4, number of independent channels (≥1)
- DB_CYCLES, 2_000_000, stable-input cycles required to accept a change (20 ms @ 100 MHz); legal range ≥2
- LONG_CYCLES, 100_000_000, debounced-high cycles before a long-press pulse (1 s @ 100 MHz); used only with LONG_PRESS_EN; must be > DB_CYCLES

- clk  input  1  system clock, all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- noisy  input  N_CH  raw asynchronous button inputs, bit i = channel i
- debounced  output  N_CH  clean level per channel
- rise  output  N_CH  one-cycle pulse on accepted press (0→1)
- fall  output  N_CH  one-cycle pulse on accepted release (1→0)
- long_press  output  N_CH  one-cycle pulse per held press exceeding LONG_CYCLES

## Operation
- Each channel is fully independent. All channels share only the clock and reset. No cross-channel arbitration.
- Synchroniser: two flops per bit; s = second flop.
- Counter cnt is ceil(log2(DB_CYCLES)) bits wide, one per channel.
- FSM states per channel:
  - LO: cnt=0. s=1 → WAIT_HI.
  - WAIT_HI: s=0 → LO, cnt cleared. s=1 and cnt==DB_CYCLES-1 → HI. Otherwise cnt+1.
  - HI: cnt=0. s=0 → WAIT_LO.
  - WAIT_LO: s=1 → HI, cnt cleared. s=0 and cnt==DB_CYCLES-1 → LO. Otherwise cnt+1.
- debounced = state ∈ {HI, WAIT_LO}. It is registered and glitch-free.
- rise is high for the single cycle after the WAIT_HI→HI transition.
- fall is high for the single cycle after the WAIT_LO→LO transition.
- HI→WAIT_LO→HI (glitch during a hold) produces no pulse.
- rise and fall of the same channel are never high together.
- The counter never wraps. It is cleared on every entry to LO or HI and on every abort.

## Timing
- Reset (asynchronous): synchroniser flops=0, state=LO, cnt=0. debounced, rise, fall and long_press are all 0.
- A button held through reset produces rise DB_CYCLES+2 cycles after reset_n deasserts.
- Latency: noisy first sampled high at edge 0 and held → debounced=1 and rise=1 after edge DB_CYCLES+2. Release is symmetric for debounced/fall.
- A pulse of noisy shorter than DB_CYCLES cycles (as seen at s) never changes debounced.
- Reset asserted mid-count aborts immediately. No pulse is emitted at or after reset assertion.
- Simultaneous events on different channels are handled in the same cycle, independently.

## Configuration
- LONG_PRESS_EN defined:
  - Each channel gets a hold counter, ceil(log2(LONG_CYCLES)) bits, cleared whenever debounced=0.
  - The hold counter increments each cycle debounced=1 and saturates at LONG_CYCLES-1.
  - long_press pulses for one cycle when the count reaches LONG_CYCLES-1, counted from the first debounced-high cycle. The pulse is emitted once per press.
  - Time spent in WAIT_LO still counts toward the hold.
- LONG_PRESS_EN undefined: no hold counters are built; long_press is tied to 0. The port list is identical in both builds.

## Test plan
- N_CH=4, DB_CYCLES=8: reset_n low 3 cycles with noisy=4'hF, then release → all outputs 0 during reset; rise=4'hF exactly 10 cycles after first sampled high; debounced=4'hF thereafter.
- Channel 0 bounce: 0/1 toggles with runs of 3 cycles for 30 cycles, then stable 1 → no pulses during bouncing; a single rise[0] 10 cycles after the last 0→1 edge; channels 1–3 stay 0.
- Held high with a 5-cycle low glitch on channel 2 → debounced[2] stays 1; fall[2]=0; rise[2]=0.
- Channel 1 pressed and channel 3 released on the same edge → rise[1] and fall[3] in the same cycle, one cycle wide.
- Reset asserted at cnt=5 in WAIT_HI → outputs 0 immediately; no rise emitted after reset; the next press debounces from cnt=0.
- LONG_PRESS_EN, LONG_CYCLES=20: hold 40 cycles → exactly one long_press pulse 20 cycles after rise. Without the macro, long_press stays 0.

Source files
------------

// File: rtl/debounce_multi.sv
// N-channel button debouncer: 2-flop synchroniser, per-channel debounce FSM and timer.
// Optional long-press detection is built when LONG_PRESS_EN is defined.
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = 2_000_000,
    parameter int LONG_CYCLES = 100_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] noisy,
    output logic [N_CH-1:0] debounced,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= noisy;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_q, rise_q, fall_q;
        logic             s;

        assign s = sync2_q[g];

        // cnt defaults to zero so every entry to LO/HI and every abort clears it
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            unique case (state_q)
                LO: begin
                    if (s) state_d = WAIT_HI;
                end
                WAIT_HI: begin
                    if (!s)                    state_d = LO;
                    else if (cnt_q == CNT_MAX) state_d = HI;
                    else                       cnt_d   = cnt_q + CNT_W'(1);
                end
                HI: begin
                    if (!s) state_d = WAIT_LO;
                end
                WAIT_LO: begin
                    if (s)                     state_d = HI;
                    else if (cnt_q == CNT_MAX) state_d = LO;
                    else                       cnt_d   = cnt_q + CNT_W'(1);
                end
                default: state_d = LO;
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= LO;
                cnt_q   <= '0;
                deb_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                deb_q   <= (state_d == HI) || (state_d == WAIT_LO);
                rise_q  <= (state_q == WAIT_HI) && (state_d == HI);
                fall_q  <= (state_q == WAIT_LO) && (state_d == LO);
            end
        end

        assign debounced[g] = deb_q;
        assign rise[g]      = rise_q;
        assign fall[g]      = fall_q;

`ifdef LONG_PRESS_EN
        localparam int HOLD_W = $clog2(LONG_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              done_q, lp_q;
        logic              at_max;

        assign at_max = deb_q && (hold_q == HOLD_MAX);

        always_comb begin
            hold_d = '0;
            if (deb_q) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
            end
        end

        // done_q remembers the pulse so a saturated hold fires only once
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hold_q <= '0;
                done_q <= 1'b0;
                lp_q   <= 1'b0;
            end else begin
                hold_q <= hold_d;
                done_q <= at_max;
                lp_q   <= at_max && !done_q;
            end
        end

        assign long_press[g] = lp_q;
`else
        assign long_press[g] = 1'b0;
`endif
    end

`ifndef LONG_PRESS_EN
    logic unused_long_cycles;
    assign unused_long_cycles = ^LONG_CYCLES;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with N_CH=4, DB_CYCLES=8, LONG_CYCLES=20.
module tb_debounce_multi;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int LC = 20;
`ifdef LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] noisy;
    logic [N-1:0] debounced;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] long_press;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH       (N),
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .noisy     (noisy),
        .debounced (debounced),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] noisy;
        int           ncyc;
        logic [N-1:0] deb;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        string        name;
    } vec_t;

    vec_t vt[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [N-1:0] d,
                           input logic [N-1:0] r, input logic [N-1:0] f);
        chk({nm, ".deb"}, debounced, d);
        chk({nm, ".rise"}, rise, r);
        chk({nm, ".fall"}, fall, f);
    endtask

    initial begin
        reset_n = 1'b0;
        noisy   = 4'hF;

        // rst_n, noisy, cycles, debounced, rise, fall at the last cycle
        vt.push_back('{1'b0, 4'hF, 3,  4'h0, 4'h0, 4'h0, "reset_hold"});
        vt.push_back('{1'b1, 4'hF, 9,  4'h0, 4'h0, 4'h0, "press_wait"});
        vt.push_back('{1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h0, "press_edge9"});
        vt.push_back('{1'b1, 4'hF, 1,  4'hF, 4'hF, 4'h0, "press_rise"});
        vt.push_back('{1'b1, 4'hF, 1,  4'hF, 4'h0, 4'h0, "press_width"});
        vt.push_back('{1'b1, 4'h0, 10, 4'hF, 4'h0, 4'h0, "rel_wait"});
        vt.push_back('{1'b1, 4'h0, 1,  4'h0, 4'h0, 4'hF, "rel_fall"});
        vt.push_back('{1'b1, 4'h0, 1,  4'h0, 4'h0, 4'h0, "rel_width"});
        vt.push_back('{1'b1, 4'hC, 10, 4'h0, 4'h0, 4'h0, "c_wait"});
        vt.push_back('{1'b1, 4'hC, 1,  4'hC, 4'hC, 4'h0, "c_rise"});
        vt.push_back('{1'b1, 4'h6, 10, 4'hC, 4'h0, 4'h0, "swap_wait"});
        vt.push_back('{1'b1, 4'h6, 1,  4'h6, 4'h2, 4'h8, "swap_edge"});
        vt.push_back('{1'b1, 4'h6, 1,  4'h6, 4'h0, 4'h0, "swap_width"});

        #1;
        chk_all("reset_t0", 4'h0, 4'h0, 4'h0);
        chk("reset_t0.long", long_press, 4'h0);

        // pulses may only appear on the last cycle of each record
        foreach (vt[i]) begin
            reset_n = vt[i].rst_n;
            noisy   = vt[i].noisy;
            for (int c = 1; c < vt[i].ncyc; c++) begin
                step();
                chk({vt[i].name, ".mid_rise"}, rise, 4'h0);
                chk({vt[i].name, ".mid_fall"}, fall, 4'h0);
            end
            step();
            chk_all(vt[i].name, vt[i].deb, vt[i].rise, vt[i].fall);
        end

        // 5-cycle low glitch on channel 2 while held
        noisy = 4'h2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("glitch_low", 4'h6, 4'h0, 4'h0);
        end
        noisy = 4'h6;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all("glitch_recover", 4'h6, 4'h0, 4'h0);
        end

        // release everything
        noisy = 4'h0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("relall.fall", fall, (k == 11) ? 4'h6 : 4'h0);
        end
        chk_all("relall_done", 4'h0, 4'h0, 4'h0);

        // channel 0 bounce, runs of 3 cycles
        for (int i = 0; i < 30; i++) begin
            noisy = (((i / 3) % 2) == 0) ? 4'h1 : 4'h0;
            step();
            chk_all("bounce", 4'h0, 4'h0, 4'h0);
        end
        noisy = 4'h1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_all("bounce_settle", (k >= 11) ? 4'h1 : 4'h0,
                    (k == 11) ? 4'h1 : 4'h0, 4'h0);
        end

        noisy = 4'h0;
        repeat (12) step();
        chk_all("ch0_released", 4'h0, 4'h0, 4'h0);

        // reset while channel 0 is at cnt=5 in WAIT_HI
        noisy = 4'h1;
        repeat (8) step();
        chk_all("pre_reset", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b0;
        #1;
        chk_all("reset_async", 4'h0, 4'h0, 4'h0);
        chk("reset_async.long", long_press, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset_mid", 4'h0, 4'h0, 4'h0);
        end

        // held through reset: fresh count, then long hold
        reset_n = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            step();
            chk_all("post_reset", (k >= 11) ? 4'h1 : 4'h0,
                    (k == 11) ? 4'h1 : 4'h0, 4'h0);
            chk("long_press", long_press,
                (LP && k == 11 + LC) ? 4'h1 : 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
